ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: READ_LATENCY, 2, RAM clock edges from address capture to valid ram_q (legal 1..4).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0/req1  input  1  requester N access request, held until granted.
REQ-005 SHALL have ports: we0/we1  input  1  requester N write (1) or read (0).
REQ-006 SHALL have ports: addr0/addr1  input  5  requester N word address.
REQ-007 SHALL have ports: wdata0/wdata1  input  4  requester N write data.
REQ-008 SHALL have ports: gnt0/gnt1  output  1  access accepted this cycle.
REQ-009 SHALL have ports: rvalid0/rvalid1  output  1  rdataN holds read result this cycle.
REQ-010 SHALL have ports: rdata0/rdata1  output  4  read result, equal to ram_q.
REQ-011 SHALL have port: ram_addr  output  5  RAM address.
REQ-012 SHALL have port: ram_wdata  output  4  RAM write data.
REQ-013 SHALL have port: ram_write  output  1  RAM write enable.
REQ-014 SHALL have port: ram_q  input  4  RAM read data.
REQ-015 SHALL have port: busy  output  1  clear sweep in progress.

Function
REQ-016 SHALL assert at most one of gnt0/gnt1 per cycle, combinationally from req0/req1, state and priority pointer.
REQ-017 SHALL, with one requester asserting req in RUN, grant it the same cycle.
REQ-018 SHALL, with both asserting req, grant the pointer's favoured requester; pointer then favours the other (round-robin).
REQ-019 SHALL leave the pointer unchanged in cycles without a grant.
REQ-020 SHALL drive ram_addr/ram_wdata/ram_write from the granted requester that cycle; ram_write = weN & gntN.
REQ-021 SHALL drive ram_write=0, ram_addr and ram_wdata=0 when nothing is granted and not clearing.
REQ-022 SHALL track each granted read in a READ_LATENCY-deep shift register of {valid, owner}.
REQ-023 SHALL, for a read granted in cycle T, assert rvalidOwner for exactly cycle T+READ_LATENCY with rdataOwner = ram_q.
REQ-024 SHALL never assert rvalid for writes; rvalid of non-owner stays 0.
REQ-025 SHALL sustain one grant per cycle, back-to-back reads delivering back-to-back rvalids in grant order.
REQ-026 SHALL not forward write data; same-address read-after-write returns whatever the RAM returns.
REQ-027 SHALL have states CLEAR and RUN; gnt0/gnt1 forced 0 in CLEAR.

Reset
REQ-028 SHALL, on reset assertion, immediately clear pipeline valids, pointer (favour requester 0), clear counter.
REQ-029 SHALL hold gnt*, rvalid*, ram_write at 0 while reset is high; in-flight reads are discarded, never delivered.
REQ-030 SHALL enter CLEAR (macro defined) or RUN (macro undefined) on reset.

Configuration
REQ-031 SHALL compile the clear sweep only when RAM_ARB_CLEAR_EN is defined.
REQ-032 SHALL, with RAM_ARB_CLEAR_EN, after reset write 0 to addresses 0..31, one per cycle ascending, busy=1, ram_write=1, then enter RUN and deassert busy (32 clear cycles).
REQ-033 SHALL, without RAM_ARB_CLEAR_EN, tie busy to 0 and grant from the first cycle after reset release.

Verification
REQ-034 SHALL cover: req0 write addr 5'h0A data 4'hA, later req0 read 5'h0A -> gnt0 same cycle, rvalid0=1 rdata0=4'hA two cycles after read grant.
REQ-035 SHALL cover: req0 and req1 reads held 4 cycles after reset -> grants 0,1,0,1; rvalids alternate, each owner-correct.
REQ-036 SHALL cover: only req1 held 3 cycles -> gnt1 every cycle, gnt0 never.
REQ-037 SHALL cover: reset pulsed one cycle after read grant -> rvalid0/rvalid1 never asserted for that read.
REQ-038 SHALL cover (RAM_ARB_CLEAR_EN): preload 5'h1F with 4'hF, reset, req0 held -> busy high 32 cycles, no gnt, then read 5'h1F returns 4'h0.
REQ-039 SHALL cover (no macro): busy=0 always, req0 granted first cycle after reset release.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters onto one single-port RAM; optional clear sweep under RAM_ARB_CLEAR_EN.
// Latency: grant is combinational; read data returns READ_LATENCY cycles after the read grant.
// Backpressure: a requester holds req until granted; no grants while reset is high or the clear sweep runs.
module ram_arbiter #(
   parameter int READ_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [4:0] addr0,
   input  logic [4:0] addr1,
   input  logic [3:0] wdata0,
   input  logic [3:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rvalid0,
   output logic       rvalid1,
   output logic [3:0] rdata0,
   output logic [3:0] rdata1,
   output logic [4:0] ram_addr,
   output logic [3:0] ram_wdata,
   output logic       ram_write,
   input  logic [3:0] ram_q,
   output logic       busy
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]              state;
   logic [4:0]              clr_cnt;
   logic                    ptr;
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [READ_LATENCY-1:0] pipe_own;
   logic                    running;
   logic                    clearing;
   logic                    rd_gnt;

`ifdef RAM_ARB_CLEAR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 5'd1;
         if (clr_cnt == 5'd31) begin
            state <= ST_RUN;
         end
      end
   end
`else
   assign state   = ST_RUN;
   assign clr_cnt = '0;
`endif

   assign running  = (state == ST_RUN) && !reset;
   assign clearing = (state == ST_CLEAR);
   assign busy     = clearing;

   // ptr=1 means requester 1 wins a tie
   assign gnt0 = running && req0 && (!req1 || !ptr);
   assign gnt1 = running && req1 && (!req0 || ptr);

   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_write = 1'b0;
      if (clearing) begin
         ram_addr  = clr_cnt;
         ram_write = !reset;
      end else if (gnt0) begin
         ram_addr  = addr0;
         ram_wdata = wdata0;
         ram_write = we0;
      end else if (gnt1) begin
         ram_addr  = addr1;
         ram_wdata = wdata1;
         ram_write = we1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (gnt0) begin
         ptr <= 1'b1;
      end else if (gnt1) begin
         ptr <= 1'b0;
      end
   end

   assign rd_gnt = (gnt0 && !we0) || (gnt1 && !we1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld <= '0;
         pipe_own <= '0;
      end else begin
         pipe_vld[0] <= rd_gnt;
         pipe_own[0] <= gnt1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

   assign rvalid0 = pipe_vld[READ_LATENCY-1] && !pipe_own[READ_LATENCY-1] && !reset;
   assign rvalid1 = pipe_vld[READ_LATENCY-1] &&  pipe_own[READ_LATENCY-1] && !reset;
   assign rdata0  = ram_q;
   assign rdata1  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: driver feeds a queue-based reference model, negedge monitor compares.
module tb_ram_arbiter;
   localparam int L = 2;
`ifdef RAM_ARB_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [3:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, ram_write, busy;
   logic [3:0] rdata0, rdata1, ram_wdata, ram_q;
   logic [4:0] ram_addr;

   always #5 clk = ~clk;

   ram_arbiter #(.READ_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
      .ram_q(ram_q), .busy(busy)
   );

   // RAM: address captured on an edge, data appears L edges later
   logic [3:0] tb_mem   [32];
   logic [3:0] ram_pipe [L];
   always @(posedge clk) begin
      if (ram_write) tb_mem[ram_addr] <= ram_wdata;
      ram_pipe[0] <= tb_mem[ram_addr];
      for (int k = 1; k < L; k++) ram_pipe[k] <= ram_pipe[k-1];
   end
   assign ram_q = ram_pipe[L-1];

   typedef struct packed {
      logic       g0;
      logic       g1;
      logic       busy;
      logic       wr;
      logic [4:0] addr;
      logic [3:0] wdata;
   } exp_t;

   typedef struct {
      int         owner;
      logic [3:0] data;
      int         due;
   } rd_t;

   exp_t exp_q[$];
   rd_t  rd_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int         ptr = 0;
   int         clear_left = 0;
   logic [3:0] mem_ref [32];
   logic       p_req   [2];
   logic       p_we    [2];
   logic [4:0] p_addr  [2];
   logic [3:0] p_wd    [2];
   logic       granted [2];

   always @(posedge clk) cyc <= cyc + 1;

   // one call = one clock cycle of stimulus plus the model's view of that cycle
   task automatic drive_cycle(input logic rst);
      exp_t e;
      rd_t  r;
      int   win;
      @(posedge clk);
      #1;
      reset  = rst;
      req0   = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
      req1   = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
      granted[0] = 1'b0;
      granted[1] = 1'b0;
      e = '0;
      if (rst) begin
         ptr = 0;
         rd_q.delete();
         clear_left = CLR ? 32 : 0;
         e.busy = CLR;
      end else if (clear_left > 0) begin
         e.busy = 1'b1;
         e.wr   = 1'b1;
         e.addr = 5'(32 - clear_left);
         mem_ref[e.addr] = 4'h0;
         clear_left--;
      end else begin
         win = -1;
         if (p_req[0] && p_req[1]) win = ptr;
         else if (p_req[0])        win = 0;
         else if (p_req[1])        win = 1;
         if (win >= 0) begin
            granted[win] = 1'b1;
            if (win == 0) e.g0 = 1'b1;
            else          e.g1 = 1'b1;
            e.addr  = p_addr[win];
            e.wdata = p_wd[win];
            if (p_we[win]) begin
               e.wr = 1'b1;
               mem_ref[p_addr[win]] = p_wd[win];
            end else begin
               r.owner = win;
               r.data  = mem_ref[p_addr[win]];
               r.due   = cyc + L;
               rd_q.push_back(r);
            end
            ptr = 1 - win;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic issue(input int id, input logic we, input logic [4:0] a, input logic [3:0] d);
      int n;
      n = 0;
      p_req[id] = 1'b1; p_we[id] = we; p_addr[id] = a; p_wd[id] = d;
      do begin
         drive_cycle(1'b0);
         n++;
      end while (!granted[id] && n < 100);
      p_req[id] = 1'b0;
      if (!granted[id]) begin
         errors++;
         $display("FAIL grant_timeout req%0d got no grant in %0d cycles, required a grant", id, n);
      end
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (clear_left > 0 && n < 100) begin
         drive_cycle(1'b0);
         n++;
      end
   endtask

   always @(negedge clk) begin
      exp_t       e, a;
      rd_t        r;
      logic [1:0] ev;
      logic [3:0] ed;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gnt0, gnt1, busy, ram_write, ram_addr, ram_wdata};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got g0=%b g1=%b busy=%b wr=%b addr=%h wd=%h required g0=%b g1=%b busy=%b wr=%b addr=%h wd=%h",
                     cyc, a.g0, a.g1, a.busy, a.wr, a.addr, a.wdata, e.g0, e.g1, e.busy, e.wr, e.addr, e.wdata);
         end
         ev = 2'b00;
         ed = 4'h0;
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r  = rd_q.pop_front();
            ev = (r.owner == 0) ? 2'b10 : 2'b01;
            ed = r.data;
         end
         checks++;
         if ({rvalid0, rvalid1} !== ev || (ev[1] && rdata0 !== ed) || (ev[0] && rdata1 !== ed)) begin
            errors++;
            $display("FAIL readback cyc=%0d got rv0=%b rv1=%b rd0=%h rd1=%h required rv0=%b rv1=%b data=%h",
                     cyc, rvalid0, rvalid1, rdata0, rdata1, ev[1], ev[0], ed);
         end
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0; granted[i] = 1'b0;
      end
      for (int i = 0; i < 32; i++) mem_ref[i] = 4'h0;

      repeat (3) drive_cycle(1'b1);
      // first access right at release (or right after the sweep), and known RAM contents
      for (int a = 0; a < 32; a++) issue(0, 1'b1, 5'(a), 4'h0);

      issue(0, 1'b1, 5'h0A, 4'hA);
      drive_cycle(1'b0);
      issue(0, 1'b0, 5'h0A, 4'h0);
      repeat (L + 1) drive_cycle(1'b0);

      // contention straight after reset: 0,1,0,1
      drive_cycle(1'b1);
      wait_clear();
      p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 5'h0A;
      p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 5'h02;
      repeat (4) begin
         drive_cycle(1'b0);
         for (int i = 0; i < 2; i++)
            if (granted[i]) p_addr[i] = 5'($urandom_range(0, 31));
      end
      p_req[0] = 1'b0;
      repeat (3) drive_cycle(1'b0);
      p_req[1] = 1'b0;
      repeat (L + 1) drive_cycle(1'b0);

      // read in flight when reset pulses must never return
      issue(0, 1'b0, 5'h0A, 4'h0);
      drive_cycle(1'b1);
      wait_clear();
      repeat (L + 2) drive_cycle(1'b0);

`ifdef RAM_ARB_CLEAR_EN
      issue(0, 1'b1, 5'h1F, 4'hF);
      drive_cycle(1'b1);
      issue(0, 1'b0, 5'h1F, 4'h0);
      repeat (L + 1) drive_cycle(1'b0);
`endif

      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!p_req[i] && $urandom_range(0, 3) != 0) begin
               p_req[i]  = 1'b1;
               p_we[i]   = 1'($urandom_range(0, 1));
               p_addr[i] = 5'($urandom_range(0, 7));
               p_wd[i]   = 4'($urandom_range(0, 15));
            end
         end
         drive_cycle($urandom_range(0, 299) == 0);
         for (int i = 0; i < 2; i++)
            if (granted[i]) p_req[i] = 1'b0;
      end

      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      wait_clear();
      repeat (L + 2) drive_cycle(1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (rd_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d reads and %0d cycles pending, required 0 and 0", rd_q.size(), exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
